// File: rtl/async_counter.sv
// Ripple binary counter. Each stage is a toggle flop clocked by the previous stage's output.
// Stage 0 alone sees clk; reset clears every stage asynchronously.
module async_counter #(
  parameter int unsigned WIDTH = 4,
  parameter bit          DOWN  = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stage_s;

  for (genvar i = 0; i < WIDTH; i++) begin : g_stage
    logic bit_q;
    logic bit_d;

    // toggle input for this stage
    always_comb begin
      bit_d = ~bit_q;
    end

    if (i == 0) begin : g_first
      // stage 0 toggles on every rising clk edge
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          bit_q <= 1'b0;
        end else begin
          bit_q <= bit_d;
        end
      end
    end else if (DOWN) begin : g_down
      // a borrow out of the lower stage is its 0->1 transition
      always_ff @(posedge stage_s[i-1] or posedge reset) begin
        if (reset) begin
          bit_q <= 1'b0;
        end else begin
          bit_q <= bit_d;
        end
      end
    end else begin : g_up
      // a carry out of the lower stage is its 1->0 transition
      always_ff @(negedge stage_s[i-1] or posedge reset) begin
        if (reset) begin
          bit_q <= 1'b0;
        end else begin
          bit_q <= bit_d;
        end
      end
    end

    assign stage_s[i] = bit_q;
  end

  assign q = stage_s;

endmodule

// File: tb/tb_async_counter.sv
// Directed bench for async_counter: up (4 and 8 bit) and down (4 bit) instances on a shared clk.
`timescale 1ns/100ps
module tb_async_counter;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       reset_dn = 1'b1;
  logic [3:0] q_up;
  logic [7:0] q_up8;
  logic [3:0] q_dn;

  int tests = 0;
  int fails = 0;
  realtime t_q3_rise = 0.0;
  realtime t_q3_fall = 0.0;

  async_counter #(.WIDTH(4), .DOWN(1'b0)) u_up  (.clk(clk), .reset(reset),    .q(q_up));
  async_counter #(.WIDTH(8), .DOWN(1'b0)) u_up8 (.clk(clk), .reset(reset),    .q(q_up8));
  async_counter #(.WIDTH(4), .DOWN(1'b1)) u_dn  (.clk(clk), .reset(reset_dn), .q(q_dn));

  // rising edges at 5, 15, 25, ...
  always #5 clk = ~clk;

  // timestamp the MSB edges of the 4-bit up counter while not in reset
  always @(posedge q_up[3]) if (!reset) t_q3_rise = $realtime;
  always @(negedge q_up[3]) if (!reset) t_q3_fall = $realtime;

  task automatic check(input string tag, input int observed, input int expected);
    tests++;
    assert (observed === expected) else begin
      fails++;
      $display("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
      $error("check %s", tag);
    end
  endtask

  initial begin
    // power-up reset spanning the 5 ns edge
    #3;
    check("reset_t3", int'(q_up), 0);
    #3;
    check("reset_after_edge5", int'(q_up), 0);
    check("reset_dn_held", int'(q_dn), 0);
    #6;
    reset = 1'b0;                          // t = 12
    check("release_no_edge", int'(q_up), 0);

    // 20 edges: 15 .. 205, wraps 15 -> 0 at 165
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk);
      #1;
      check($sformatf("up_edge%0d", n), int'(q_up), n % 16);
      if (n == 15) check("up_max", int'(q_up), 15);
      if (n == 16) check("up_wrap", int'(q_up), 0);
    end
    #6;                                    // t = 212
    check("up_end_212", int'(q_up), 4);
    check("up8_no_wrap", int'(q_up8), 20);
    check("q3_rise_85", int'(t_q3_rise), 85);
    check("q3_half_period", int'(t_q3_fall - t_q3_rise), 80);

    // reset held across the 215 edge masks it
    reset = 1'b1;
    #1;
    check("rst_immediate", int'(q_up), 0);
    #3;                                    // t = 216
    check("rst_masks_edge", int'(q_up), 0);
    #6;
    reset = 1'b0;                          // t = 222
    for (int n = 1; n <= 9; n++) begin
      @(posedge clk);
      #1;
    end
    check("count_to_9", int'(q_up), 9);  // t = 306

    // short pulse strictly between edges
    #6;
    reset = 1'b1;                          // t = 312
    #1;
    check("mid_rst_clear", int'(q_up), 0);
    check("mid_rst_clear8", int'(q_up8), 0);
    #1;
    reset = 1'b0;                          // t = 314
    check("mid_rst_hold", int'(q_up), 0);
    @(posedge clk);
    #1;
    check("resume_1", int'(q_up), 1);
    @(posedge clk);
    #1;
    check("resume_2", int'(q_up), 2);

    // down counter: release between edges, then 0 -> 15 -> 14 -> 13
    #3;
    reset_dn = 1'b0;
    check("dn_release", int'(q_dn), 0);
    @(posedge clk);
    #1;
    check("dn_wrap_15", int'(q_dn), 15);
    @(posedge clk);
    #1;
    check("dn_14", int'(q_dn), 14);
    @(posedge clk);
    #1;
    check("dn_13", int'(q_dn), 13);
    reset_dn = 1'b1;
    #1;
    check("dn_async_clear", int'(q_dn), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // watchdog
  initial begin
    #5000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/async_counter.md
Name: async_counter

Overview:
- Ripple (asynchronous) binary counter: each flop stage is clocked by the output of the previous stage, not by the common clock.
- Default configuration: 4-bit up-counter advancing once per rising edge of clk.
- Used as a low-power free-running event/divider counter where transient ripple states on q are tolerable.
- q bits also serve as clk/2, clk/4, clk/8 and clk/16 divided outputs.

Parameters:
- WIDTH, 4, number of counter stages / width of q (legal range 1..32).
- DOWN, 0, 0 = up-counter; 1 = down-counter (same ripple structure, inverted stage clocking).

Ports:
- clk  input  1  counter clock; drives stage 0 only, rising-edge sensitive.
- reset  input  1  asynchronous, active-high reset; clears every stage immediately.
- q  output  WIDTH  counter value; q[0] is LSB, each bit a registered flop output.

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-high.
- Reset:
  - While reset=1, all stages are held at 0, so q=0 regardless of clk.
  - Reset acts without a clock edge and applies to all stages simultaneously.
  - Deassertion is asynchronous; the first count occurs on the first clk rising edge strictly after deassertion.
- Stage 0 toggles on every rising edge of clk.
- Stage i (i>=1), DOWN=0: toggles on the falling edge of q[i-1]. Net effect is q increments by 1 per clk rising edge.
- Stage i (i>=1), DOWN=1: toggles on the rising edge of q[i-1]. Net effect is q decrements by 1 per clk rising edge.
- Each stage is an individual toggle flop with its own clock and the shared async reset. No stage may use clk directly except stage 0.
- Wrap-around:
  - Up: 2^WIDTH-1 -> 0 (default 15 -> 0).
  - Down: 0 -> 2^WIDTH-1 (default 0 -> 15).
  - No terminal-count output, no saturation.
- Latency:
  - q[0] updates one flop delay after the clk edge; q[i] updates i+1 flop delays after the edge.
  - During ripple, q may briefly show intermediate values. Consumers sample q only after settling; the block guarantees settling within half a clk period for WIDTH<=8.
  - In zero-delay simulation q settles in the same timestep as the clk edge.
- Reset mid-operation: any count state is cleared to 0 at once, including during a ripple in progress. No partial states persist after reset asserts.
- Reset and clk edge coinciding: reset dominates and q=0.
- No enable, load or carry ports. The counter runs whenever reset=0.

Test Plan:
- Power-up reset: clk period 10 ns (rising at 5, 15, ...), reset=1 for 0–12 ns -> q=0 throughout; the clk edge at 5 ns has no effect.
- Counting: release reset at 12 ns -> q=1 after 15 ns edge, q=2 after 25 ns edge, q=n after the n-th edge past release.
- Wrap: continue to 212 ns (20 edges) -> q passes 15 -> 0 at the 16th edge (165 ns) and ends at q=4.
- Ripple structure: check q[0] toggles every clk edge and q[1] toggles only on q[0] falling edges -> q[3] has a period of 160 ns (clk/16).
- Mid-run async reset: pulse reset=1 at 103 ns for 2 ns (between edges, q=9) -> q=0 immediately without a clk edge; next edge at 105 ns is masked only if reset is still high; counting resumes at 1 on the following edge.
- DOWN=1 instance: reset, then 3 clk edges -> q=15, 14, 13.
